alu_sched: RTL and testbench
============================

Name: alu_sched

Overview:
Round-robin scheduler that shares the single 32-bit Y86 ALU between two requesters. Port 0 is the execute stage; port 1 is the address/auxiliary unit. It drives the ALU operand and opcode inputs and samples valE/ZSO combinationally in the grant cycle. It registers one result per requester and owns the architectural condition-code register (CC). The ALU itself stays purely combinational; this block supplies all sequencing.

Parameters:
FIXED_PRI, 0, 1 = port 0 always wins a conflict; 0 = round-robin.
CC_RST, 3'b100, reset value of CC in ZSO order: Z=1, S=0, O=0.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
req_valid  in  2  per-port request valid (bit i = port i)
req_ready  out  2  per-port grant; a transfer occurs when valid & ready
req_a0 / req_b0  in  32 each  port 0 operands (ALU aluA / aluB)
req_a1 / req_b1  in  32 each  port 1 operands
req_op0 / req_op1  in  4 each  ALU opcode: 0 add, 1 sub(B-A), 2 and, 3 xor
req_setcc0  in  1  port 0 only: load CC from this operation's ZSO
alu_a / alu_b  out  32 each  to ALU aluA / aluB
alu_op  out  4  to ALU aluOP
alu_vale  in  32  from ALU valE
alu_zso  in  3  from ALU ZSO
rsp_valid  out  2  per-port result valid
rsp_ready  in  2  per-port result accept
rsp_data0 / rsp_data1  out  32 each  registered valE
rsp_zso0 / rsp_zso1  out  3 each  registered ZSO
cc  out  3  architectural condition codes {Z,S,O}
busy  out  1  high in any cycle where the ALU is granted

Behaviour:
- Reset (synchronous, rst=1 at posedge): rsp_valid=0; rsp_data*=0; rsp_zso*=0; cc=CC_RST; rr pointer = port 0 was last granted (port 1 preferred next). The ALU drive outputs are combinational, with alu_a/alu_b/alu_op = 0 when nothing is granted.
- slot_free[i] = ~rsp_valid[i] | rsp_ready[i]. A port is eligible when req_valid[i] & slot_free[i].
- Arbitration: at most one grant per cycle.
  - If one port is eligible, it is granted.
  - If both are eligible: with FIXED_PRI=1, port 0 wins; otherwise the port not granted last wins.
  - The rr pointer updates only on a grant.
- req_ready[i] = grant[i]. It is combinational and may depend on req_valid. Requesters hold operands stable while valid & !ready.
- Grant cycle N: the ALU is driven from the granted port. At posedge N+1, rsp_data/rsp_zso[i] load alu_vale/alu_zso and rsp_valid[i] goes to 1. Latency is one cycle.
- Throughput: one op per cycle total. A single port sustains one op per cycle when rsp_ready[i] is held high.
- Result slot: rsp_valid[i] clears on rsp_ready[i] unless a new grant to port i occurs in the same cycle. Drain and refill in the same cycle keeps the slot valid with the new data. Data is stable while valid & !ready.
- CC: loads alu_zso at the end of a port-0 grant cycle with req_setcc0=1. It is otherwise held and is never written by port 1.
- cc reflects the update one cycle after the grant, coincident with rsp_valid[0].
- Opcodes 4..15 pass through unchanged. The ALU decodes op[1:0], and this block does not filter them.
- rst mid-operation: a pending slot is discarded with no response, and cc returns to CC_RST.

Optional Feature:
Macro ALU_SCHED_STATS_EN.
- Defined: adds outputs stat_gnt0, stat_gnt1 and stat_conflict (32 bits each).
  - stat_gnt0 / stat_gnt1 increment per grant to the respective port.
  - stat_conflict increments in cycles where both ports are eligible.
  - All three clear on rst and wrap at 2^32-1 to 0.
- Undefined: these ports and their counters are absent, and all other behaviour is identical.

Decomposition:
- Shared package y86_alu_pkg holds:
  - ALU opcode constants ALU_ADD=4'h0, ALU_SUB=4'h1, ALU_AND=4'h2, ALU_XOR=4'h3;
  - ZSO bit indices ZSO_Z=2, ZSO_S=1, ZSO_O=0;
  - CC reset constant;
  - the width constant 32.
- One natural sub-module: rr_arb2 (2-way round-robin/fixed-priority arbiter with last-grant pointer). The result slots and CC stay in alu_sched.

Test Plan:
- Reset check: after rst, cc=3'b100, rsp_valid=00, busy=0, alu_op=0.
- Single op: port 0 valid, a=5, b=7, op=1, setcc=1. Expect ready0=1 in cycle N; at N+1 rsp_data0=2, rsp_zso0=000, cc=000.
- Zero result: port 0 a=3, b=3, op=1, setcc=1. Expect rsp_data0=0, cc=100. Then port 1 a=3, b=3, op=3: expect rsp_data1=0 and cc still 100.
- Conflict, FIXED_PRI=0: both ports valid continuously with rsp_ready=11. Grants alternate 1,0,1,0 (port 1 first after reset). Each rsp_valid toggles with one-cycle latency; busy=1 every cycle.
- Back-pressure: port 1 rsp_ready=0 with rsp_valid1=1 and a new port-1 request. Expect ready1=0 and port 0 still granted. Raise rsp_ready1: in the same cycle ready1=1 and the slot refills with the new data.
- Reset mid-stream: assert rst while rsp_valid0=1 and cc=010. Next cycle rsp_valid=00, cc=100, and no stale response appears afterwards.

Source files
------------

// File: rtl/y86_alu_pkg.sv
// Shared Y86 ALU definitions: opcodes, ZSO bit positions, datapath width and CC reset value.
package y86_alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam int ZSO_Z = 2;
  localparam int ZSO_S = 1;
  localparam int ZSO_O = 0;

  localparam logic [2:0] CC_RST_VAL = 3'b100;

  typedef enum logic {
    PORT_EXE = 1'b0,
    PORT_AUX = 1'b1
  } port_e;

endpackage

// File: rtl/alu_sched_if.sv
// Request/response bundle between the two ALU requesters and alu_sched.
interface alu_sched_if;
  import y86_alu_pkg::*;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req_a0;
  logic [DATA_W-1:0] req_b0;
  logic [DATA_W-1:0] req_a1;
  logic [DATA_W-1:0] req_b1;
  logic [3:0]        req_op0;
  logic [3:0]        req_op1;
  logic              req_setcc0;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DATA_W-1:0] rsp_data0;
  logic [DATA_W-1:0] rsp_data1;
  logic [2:0]        rsp_zso0;
  logic [2:0]        rsp_zso1;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, req_setcc0, rsp_ready,
    input  req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_zso0, rsp_zso1
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, req_setcc0, rsp_ready,
    output req_ready, rsp_valid, rsp_data0, rsp_data1, rsp_zso0, rsp_zso1
  );

endinterface

// File: rtl/alu_sched_rr_arb2.sv
// Two-way arbiter: round-robin on a last-grant pointer, or fixed priority to port 0.
module rr_arb2
  import y86_alu_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_e last_reg;
  port_e last_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg <= PORT_EXE;
    end else begin
      last_reg <= last_next;
    end
  end

  // On a conflict the port that did not win last time goes first.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (FIXED_PRI || last_reg == PORT_AUX) ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_next = last_reg;
    if (gnt[0]) begin
      last_next = PORT_EXE;
    end else if (gnt[1]) begin
      last_next = PORT_AUX;
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one combinational Y86 ALU between execute (port 0) and aux (port 1); owns result slots and CC.
// Optional grant/conflict counters are enabled with `define ALU_SCHED_STATS_EN.
module alu_sched
  import y86_alu_pkg::*;
#(
  parameter bit         FIXED_PRI = 1'b0,
  parameter logic [2:0] CC_RST    = CC_RST_VAL
) (
  input  logic              clk,
  input  logic              rst,
  alu_sched_if.slave        bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_vale,
  input  logic [2:0]        alu_zso,
  output logic [2:0]        cc,
  output logic              busy
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [31:0]       stat_gnt0,
  output logic [31:0]       stat_gnt1,
  output logic [31:0]       stat_conflict
`endif
);

  logic [1:0]        slot_free;
  logic [1:0]        elig;
  logic [1:0]        gnt;
  logic [1:0]        rsp_valid_w;
  logic [DATA_W-1:0] rsp_data_w [2];
  logic [2:0]        rsp_zso_w  [2];
  logic [2:0]        cc_reg;

  // A slot can take a new result if it is empty or being drained this cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic [2:0]        zso_reg;

    assign slot_free[gi] = ~valid_reg | bus.rsp_ready[gi];
    assign elig[gi]      = bus.req_valid[gi] & slot_free[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
        zso_reg   <= '0;
      end else if (gnt[gi]) begin
        valid_reg <= 1'b1;
        data_reg  <= alu_vale;
        zso_reg   <= alu_zso;
      end else if (bus.rsp_ready[gi]) begin
        valid_reg <= 1'b0;
      end
    end

    assign rsp_valid_w[gi] = valid_reg;
    assign rsp_data_w[gi]  = data_reg;
    assign rsp_zso_w[gi]   = zso_reg;
  end

  rr_arb2 #(
    .FIXED_PRI(FIXED_PRI)
  ) u_arb (
    .clk(clk),
    .rst(rst),
    .req(elig),
    .gnt(gnt)
  );

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (gnt[0]) begin
      alu_a  = bus.req_a0;
      alu_b  = bus.req_b0;
      alu_op = bus.req_op0;
    end else if (gnt[1]) begin
      alu_a  = bus.req_a1;
      alu_b  = bus.req_b1;
      alu_op = bus.req_op1;
    end
  end

  // Only the execute stage may update the architectural flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_reg <= CC_RST;
    end else if (gnt[0] && bus.req_setcc0) begin
      cc_reg <= alu_zso;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_w;
  assign bus.rsp_data0 = rsp_data_w[0];
  assign bus.rsp_data1 = rsp_data_w[1];
  assign bus.rsp_zso0  = rsp_zso_w[0];
  assign bus.rsp_zso1  = rsp_zso_w[1];
  assign cc            = cc_reg;
  assign busy          = |gnt;

`ifdef ALU_SCHED_STATS_EN
  logic [31:0] stat_gnt0_reg;
  logic [31:0] stat_gnt1_reg;
  logic [31:0] stat_conflict_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_gnt0_reg     <= '0;
      stat_gnt1_reg     <= '0;
      stat_conflict_reg <= '0;
    end else begin
      if (gnt[0]) stat_gnt0_reg <= stat_gnt0_reg + 32'd1;
      if (gnt[1]) stat_gnt1_reg <= stat_gnt1_reg + 32'd1;
      if (&elig)  stat_conflict_reg <= stat_conflict_reg + 32'd1;
    end
  end

  assign stat_gnt0     = stat_gnt0_reg;
  assign stat_gnt1     = stat_gnt1_reg;
  assign stat_conflict = stat_conflict_reg;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed scenarios plus randomized traffic against a behavioural model.
// Stats counters are also checked when ALU_SCHED_STATS_EN is defined.
module tb_alu_sched;
  import y86_alu_pkg::*;

  localparam bit FIXED_PRI = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_sched_if bus ();

  logic [31:0] alu_a, alu_b, alu_vale;
  logic [3:0]  alu_op;
  logic [2:0]  alu_zso, cc;
  logic        busy;
`ifdef ALU_SCHED_STATS_EN
  logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

  alu_sched #(
    .FIXED_PRI(FIXED_PRI),
    .CC_RST(3'b100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_op(alu_op),
    .alu_vale(alu_vale),
    .alu_zso(alu_zso),
    .cc(cc),
    .busy(busy)
`ifdef ALU_SCHED_STATS_EN
    ,
    .stat_gnt0(stat_gnt0),
    .stat_gnt1(stat_gnt1),
    .stat_conflict(stat_conflict)
`endif
  );

  // Y86 ALU semantics from signed arithmetic: returns {Z,S,O,valE}.
  function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    longint sa, sb, exact;
    logic [31:0] r;
    logic o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    o  = 1'b0;
    case (op[1:0])
      2'd0: begin exact = sa + sb; r = a + b; o = (exact != longint'($signed(r))); end
      2'd1: begin exact = sb - sa; r = b - a; o = (exact != longint'($signed(r))); end
      2'd2: r = a & b;
      default: r = a ^ b;
    endcase
    return {(r == 32'd0), ($signed(r) < 0), o, r};
  endfunction

  always_comb {alu_zso, alu_vale} = alu_ref(alu_a, alu_b, alu_op);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit          mv [2];
  logic [31:0] md [2];
  logic [2:0]  mz [2];
  logic [2:0]  mcc;
  int          last_port;
  int          g;
  logic [1:0]  obs_ready;
  logic [31:0] s_g0, s_g1, s_conf;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
      mz[i] = '0;
    end
    mcc       = 3'b100;
    last_port = 0;
    g         = -1;
    s_g0      = '0;
    s_g1      = '0;
    s_conf    = '0;
  endtask

  task automatic check_regs();
    check("rsp_valid", 32'(bus.rsp_valid), 32'({mv[1], mv[0]}));
    check("rsp_data0", bus.rsp_data0, md[0]);
    check("rsp_data1", bus.rsp_data1, md[1]);
    check("rsp_zso0", 32'(bus.rsp_zso0), 32'(mz[0]));
    check("rsp_zso1", 32'(bus.rsp_zso1), 32'(mz[1]));
    check("cc", 32'(cc), 32'(mcc));
`ifdef ALU_SCHED_STATS_EN
    check("stat_gnt0", stat_gnt0, s_g0);
    check("stat_gnt1", stat_gnt1, s_g1);
    check("stat_conflict", stat_conflict, s_conf);
`endif
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.req_valid  = 2'b00;
    bus.req_a0     = '0;
    bus.req_b0     = '0;
    bus.req_a1     = '0;
    bus.req_b1     = '0;
    bus.req_op0    = '0;
    bus.req_op1    = '0;
    bus.req_setcc0 = 1'b0;
    bus.rsp_ready  = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst alu_op", 32'(alu_op), 32'd0);
    check_regs();
    $display("txn: reset");
  endtask

  task automatic step(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [3:0] op0, input logic sc, input logic [31:0] a1,
                      input logic [31:0] b1, input logic [3:0] op1, input logic [1:0] rr);
    bit e0, e1;
    int gp;
    logic [31:0] ea, eb;
    logic [3:0]  eop;
    logic [34:0] res;
    bus.req_valid  = v;
    bus.req_a0     = a0;
    bus.req_b0     = b0;
    bus.req_op0    = op0;
    bus.req_setcc0 = sc;
    bus.req_a1     = a1;
    bus.req_b1     = b1;
    bus.req_op1    = op1;
    bus.rsp_ready  = rr;
    #1;
    e0 = v[0] && (!mv[0] || rr[0]);
    e1 = v[1] && (!mv[1] || rr[1]);
    if (e0 && e1) gp = (FIXED_PRI || last_port == 1) ? 0 : 1;
    else if (e0)  gp = 0;
    else if (e1)  gp = 1;
    else          gp = -1;
    ea = '0; eb = '0; eop = '0;
    if (gp == 0) begin ea = a0; eb = b0; eop = op0; end
    else if (gp == 1) begin ea = a1; eb = b1; eop = op1; end
    obs_ready = bus.req_ready;
    check("req_ready", 32'(bus.req_ready), (gp < 0) ? 32'd0 : (32'd1 << gp));
    check("busy", 32'(busy), (gp >= 0) ? 32'd1 : 32'd0);
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    check("alu_op", 32'(alu_op), 32'(eop));
    res = alu_ref(ea, eb, eop);
    if (e0 && e1) s_conf++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (i == gp) begin
        mv[i] = 1'b1;
        md[i] = res[31:0];
        mz[i] = res[34:32];
      end else if (rr[i]) begin
        mv[i] = 1'b0;
      end
    end
    if (gp >= 0) begin
      last_port = gp;
      if (gp == 0) s_g0++; else s_g1++;
      if (gp == 0 && sc) mcc = res[34:32];
      $display("txn: port %0d op=%h a=%h b=%h -> %h zso=%b", gp, eop, ea, eb, res[31:0], res[34:32]);
    end
    g = gp;
    check_regs();
  endtask

  logic [1:0]  rv;
  logic [31:0] ra0, rb0, ra1, rb1;
  logic [3:0]  rop0, rop1;
  logic        rsc;
  logic [1:0]  rrdy;

  initial begin
    do_reset();

    // Single op: 7 - 5 = 2, flags clear
    step(2'b01, 32'd5, 32'd7, ALU_SUB, 1'b1, 32'd0, 32'd0, ALU_ADD, 2'b11);
    check("single ready0", 32'(obs_ready), 32'd1);
    check("single data0", bus.rsp_data0, 32'd2);
    check("single zso0", 32'(bus.rsp_zso0), 32'd0);
    check("single cc", 32'(cc), 32'd0);

    // Zero result on both ports; port 1 must not touch CC
    step(2'b01, 32'd3, 32'd3, ALU_SUB, 1'b1, 32'd0, 32'd0, ALU_ADD, 2'b11);
    check("zero data0", bus.rsp_data0, 32'd0);
    check("zero cc", 32'(cc), 32'b100);
    step(2'b10, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd3, 32'd3, ALU_XOR, 2'b11);
    check("zero data1", bus.rsp_data1, 32'd0);
    check("zero cc held", 32'(cc), 32'b100);

    // Conflict with round-robin: port 1 first after reset, then alternate
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(2'b11, $urandom, $urandom, 4'($urandom_range(0, 3)), 1'b0,
           $urandom, $urandom, 4'($urandom_range(0, 3)), 2'b11);
      check("conflict gnt", 32'(obs_ready), (k % 2 == 0) ? 32'd2 : 32'd1);
    end

    // Back-pressure on port 1, then drain and refill in the same cycle
    step(2'b10, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd1, 32'd1, ALU_ADD, 2'b11);
    step(2'b11, 32'd9, 32'd1, ALU_ADD, 1'b0, 32'd10, 32'd4, ALU_ADD, 2'b01);
    check("bp ready", 32'(obs_ready), 32'd1);
    check("bp data1 held", bus.rsp_data1, 32'd2);
    step(2'b10, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd10, 32'd4, ALU_ADD, 2'b11);
    check("refill ready", 32'(obs_ready), 32'd2);
    check("refill valid1", 32'(bus.rsp_valid[1]), 32'd1);
    check("refill data1", bus.rsp_data1, 32'd14);

    // Reset with a pending port-0 result and cc=010
    step(2'b01, 32'd0, 32'hFFFF_FFFE, ALU_ADD, 1'b1, 32'd0, 32'd0, ALU_ADD, 2'b00);
    check("pre-rst valid0", 32'(bus.rsp_valid[0]), 32'd1);
    check("pre-rst cc", 32'(cc), 32'b010);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(2'b00, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd0, 32'd0, ALU_ADD, 2'b00);
      check("post-rst valid", 32'(bus.rsp_valid), 32'd0);
    end

    // Randomized traffic; a blocked request holds its operands
    rv = 2'b00;
    for (int k = 0; k < 600; k++) begin
      if (!(rv[0] && g != 0)) begin
        rv[0] = ($urandom_range(0, 3) != 0);
        ra0   = $urandom;
        rb0   = ($urandom_range(0, 3) == 0) ? ra0 : $urandom;
        rop0  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
        rsc   = 1'($urandom_range(0, 1));
      end
      if (!(rv[1] && g != 1)) begin
        rv[1] = ($urandom_range(0, 3) != 0);
        ra1   = $urandom;
        rb1   = ($urandom_range(0, 3) == 0) ? ra1 : $urandom;
        rop1  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      end
      rrdy[0] = ($urandom_range(0, 9) < 7);
      rrdy[1] = ($urandom_range(0, 9) < 7);
      step(rv, ra0, rb0, rop0, rsc, ra1, rb1, rop1, rrdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
